// File: rtl/bist_controller.sv
// bist_controller
//
// Sequencer for the built-in self-test of the radix-4 multiplier. It owns the
// active-low synchronous resets of the LFSR pattern generator and the MISR,
// releases them in order (LFSR first, MISR once the multiplier pipeline is
// primed), counts the issued patterns, waits for the MISR to report ready,
// and compares the captured signature against a golden value.
//
// Parameters
//   N_PATTERNS  patterns applied per run (<= 63, pattern_count never wraps)
//   PIPE_LAT    LFSR-to-product latency in cycles, 0..7 (length of PRIME)
//   GOLDEN_SIG  expected final signature
//   TIMEOUT     RUN cycles allowed before misr_ready must be seen (<= 256)
//
// Ports
//   clk                 clock, rising edge
//   reset_to_bist_ctrl  asynchronous active-low reset
//   start               level; a rising edge seen in IDLE/DONE launches a run
//   misr_ready          MISR has compressed all results
//   signature           current MISR signature
//   reset_to_lfsr       active-low reset to the pattern generator
//   reset_to_misr       active-low reset to the MISR
//   lfsr_enable         advances the pattern generator
//   pattern_count       patterns issued in this run
//   sig_captured        signature latched in COMPARE
//   busy                high in CLEAR, PRIME, RUN, COMPARE
//   done                high in DONE
//   pass                signature matched GOLDEN_SIG (valid while done)
//   timeout_err         misr_ready never arrived (valid while done)
//
// All outputs are registered.

module bist_controller #(
    parameter int unsigned N_PATTERNS = 31,
    parameter int unsigned PIPE_LAT   = 1,
    parameter logic [15:0] GOLDEN_SIG = 16'h0000,
    parameter int unsigned TIMEOUT    = 48
) (
    input  logic        clk,
    input  logic        reset_to_bist_ctrl,
    input  logic        start,
    input  logic        misr_ready,
    input  logic [15:0] signature,
    output logic        reset_to_lfsr,
    output logic        reset_to_misr,
    output logic        lfsr_enable,
    output logic [5:0]  pattern_count,
    output logic [15:0] sig_captured,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StPrime,
        StRun,
        StCompare,
        StDone
    } state_e;

    localparam logic [5:0] NPat        = 6'(N_PATTERNS);
    localparam logic [7:0] PrimeLast   = (PIPE_LAT > 0) ? 8'(PIPE_LAT - 1) : 8'd0;
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);
    localparam logic [7:0] ClearLast   = 8'd1;

    state_e      state_q;
    logic        start_q;
    logic        start_go_q;
    logic [7:0]  cnt_q;
    logic        rst_lfsr_q;
    logic        rst_misr_q;
    logic        lfsr_en_q;
    logic [5:0]  pat_cnt_q;
    logic [15:0] sig_q;
    logic        busy_q;
    logic        done_q;
    logic        pass_q;
    logic        tmo_q;

    // Count the pattern issued during the current cycle; saturates at NPat.
    logic [5:0]  pat_cnt_d;

    always_comb begin
        pat_cnt_d = pat_cnt_q;
        if (lfsr_en_q && (pat_cnt_q < NPat)) begin
            pat_cnt_d = pat_cnt_q + 6'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_to_bist_ctrl) begin
        if (!reset_to_bist_ctrl) begin
            state_q    <= StIdle;
            start_q    <= 1'b0;
            start_go_q <= 1'b0;
            cnt_q      <= 8'd0;
            rst_lfsr_q <= 1'b0;
            rst_misr_q <= 1'b0;
            lfsr_en_q  <= 1'b0;
            pat_cnt_q  <= 6'd0;
            sig_q      <= 16'h0000;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            start_q    <= start;
            // Launch request is registered: an edge sampled at edge t makes the
            // FSM enter CLEAR at edge t+1. Edges outside IDLE/DONE are dropped here.
            start_go_q <= start & ~start_q & ((state_q == StIdle) | (state_q == StDone));

            unique case (state_q)
                StIdle, StDone: begin
                    if (start_go_q) begin
                        state_q    <= StClear;
                        cnt_q      <= 8'd0;
                        rst_lfsr_q <= 1'b0;
                        rst_misr_q <= 1'b0;
                        lfsr_en_q  <= 1'b0;
                        pat_cnt_q  <= 6'd0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        pass_q     <= 1'b0;
                        tmo_q      <= 1'b0;
                    end
                end

                // Both resets low for two cycles so the MISR seeds itself.
                StClear: begin
                    if (cnt_q == ClearLast) begin
                        cnt_q      <= 8'd0;
                        rst_lfsr_q <= 1'b1;
                        lfsr_en_q  <= (NPat != 6'd0);
                        if (PIPE_LAT == 0) begin
                            state_q    <= StRun;
                            rst_misr_q <= 1'b1;
                        end else begin
                            state_q <= StPrime;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end

                // LFSR runs while the MISR is still held, filling the multiplier
                // pipeline so the first compressed value is a real product.
                StPrime: begin
                    pat_cnt_q <= pat_cnt_d;
                    lfsr_en_q <= (pat_cnt_d < NPat);
                    if (cnt_q == PrimeLast) begin
                        state_q    <= StRun;
                        rst_misr_q <= 1'b1;
                        cnt_q      <= 8'd0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end

                // cnt_q is the watchdog here; misr_ready has priority over it.
                StRun: begin
                    pat_cnt_q <= pat_cnt_d;
                    lfsr_en_q <= (pat_cnt_d < NPat);
                    if (misr_ready) begin
                        state_q   <= StCompare;
                        lfsr_en_q <= 1'b0;
                    end else if (cnt_q == TimeoutLast) begin
                        state_q   <= StDone;
                        lfsr_en_q <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        pass_q    <= 1'b0;
                        tmo_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end

                // Result fields and done are updated on the same edge.
                StCompare: begin
                    state_q <= StDone;
                    sig_q   <= signature;
                    pass_q  <= (signature == GOLDEN_SIG);
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign reset_to_lfsr = rst_lfsr_q;
    assign reset_to_misr = rst_misr_q;
    assign lfsr_enable   = lfsr_en_q;
    assign pattern_count = pat_cnt_q;
    assign sig_captured  = sig_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign timeout_err   = tmo_q;

endmodule

// File: tb/tb_bist_controller.sv
// Bench for bist_controller. Three builds (PIPE_LAT = 1, 0, 3) run side by
// side from the same start/reset stimulus. Each has a small MISR stand-in that
// raises ready a chosen number of cycles after its reset is released. Expected
// outputs come from a timeline model: for a run launched at edge t, every
// output is a closed-form function of k = edge - t.

module tb_bist_controller;

    localparam logic [15:0] Golden = 16'hA5C3;
    localparam int          NPat   = 31;
    localparam int          Tmo    = 48;
    localparam int          NDut   = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start;
    logic        misr_ready [NDut];
    logic [15:0] signature  [NDut];

    logic        rtl   [NDut];
    logic        rtm   [NDut];
    logic        en    [NDut];
    logic [5:0]  pc    [NDut];
    logic [15:0] sigc  [NDut];
    logic        busy  [NDut];
    logic        done  [NDut];
    logic        pass  [NDut];
    logic        terr  [NDut];

    bist_controller #(
        .N_PATTERNS(NPat), .PIPE_LAT(1), .GOLDEN_SIG(Golden), .TIMEOUT(Tmo)
    ) u_dut0 (
        .clk(clk), .reset_to_bist_ctrl(rst_n), .start(start),
        .misr_ready(misr_ready[0]), .signature(signature[0]),
        .reset_to_lfsr(rtl[0]), .reset_to_misr(rtm[0]), .lfsr_enable(en[0]),
        .pattern_count(pc[0]), .sig_captured(sigc[0]), .busy(busy[0]),
        .done(done[0]), .pass(pass[0]), .timeout_err(terr[0])
    );

    bist_controller #(
        .N_PATTERNS(NPat), .PIPE_LAT(0), .GOLDEN_SIG(Golden), .TIMEOUT(Tmo)
    ) u_dut1 (
        .clk(clk), .reset_to_bist_ctrl(rst_n), .start(start),
        .misr_ready(misr_ready[1]), .signature(signature[1]),
        .reset_to_lfsr(rtl[1]), .reset_to_misr(rtm[1]), .lfsr_enable(en[1]),
        .pattern_count(pc[1]), .sig_captured(sigc[1]), .busy(busy[1]),
        .done(done[1]), .pass(pass[1]), .timeout_err(terr[1])
    );

    bist_controller #(
        .N_PATTERNS(NPat), .PIPE_LAT(3), .GOLDEN_SIG(Golden), .TIMEOUT(Tmo)
    ) u_dut2 (
        .clk(clk), .reset_to_bist_ctrl(rst_n), .start(start),
        .misr_ready(misr_ready[2]), .signature(signature[2]),
        .reset_to_lfsr(rtl[2]), .reset_to_misr(rtm[2]), .lfsr_enable(en[2]),
        .pattern_count(pc[2]), .sig_captured(sigc[2]), .busy(busy[2]),
        .done(done[2]), .pass(pass[2]), .timeout_err(terr[2])
    );

    int unsigned n_checks;
    int unsigned n_errors;
    int          cyc;
    logic        sq;

    // Environment settings for the current run (shared by all three builds).
    logic        rdy_mode;
    int          d_rdy;
    logic [15:0] sig_run;
    int          scnt [NDut];

    // Per-build model state.
    logic        has_run  [NDut];
    int          t0       [NDut];
    int          dk       [NDut];
    int          exit_k   [NDut];
    logic        tmo      [NDut];
    logic [15:0] cap      [NDut];
    logic [28:0] prev_vec [NDut];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input int i);
        if (i == 0) return 1;
        if (i == 1) return 0;
        return 3;
    endfunction

    // {rtl, rtm, en, pc[5:0], sig[15:0], busy, done, pass, terr}
    function automatic logic [28:0] got_vec(input int i);
        return {rtl[i], rtm[i], en[i], pc[i], sigc[i], busy[i], done[i], pass[i], terr[i]};
    endfunction

    function automatic logic [28:0] exp_vec(input int i);
        int k, m, r;
        logic rl, rm, e, b, dn, ps, te;
        logic [15:0] sg;
        if (!has_run[i]) return prev_vec[i];
        k = cyc - t0[i];
        if (k <= 0) return prev_vec[i];
        r = 3 + lat_of(i);
        // Patterns issued = enabled cycles from k=3 up to leaving RUN, capped.
        m = k;
        if (exit_k[i] < m) m = exit_k[i];
        if (NPat + 3 < m) m = NPat + 3;
        m = m - 3;
        if (m < 0) m = 0;
        rl = (k >= 3);
        rm = (k >= r);
        e  = (k >= 3) && (m < NPat) && (k < exit_k[i]);
        b  = (k < dk[i]);
        dn = (k >= dk[i]);
        te = dn && tmo[i];
        ps = dn && !tmo[i] && (cap[i] == Golden);
        sg = (dn && !tmo[i]) ? cap[i] : prev_vec[i][19:4];
        return {rl, rm, e, 6'(m), sg, b, dn, ps, te};
    endfunction

    function automatic logic all_done();
        for (int i = 0; i < NDut; i++) begin
            if (!has_run[i] || (cyc - t0[i] < dk[i])) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NDut; i++) begin
            has_run[i]  = 1'b0;
            prev_vec[i] = '0;
            t0[i]       = 0;
            dk[i]       = 0;
            exit_k[i]   = 0;
            tmo[i]      = 1'b0;
            cap[i]      = '0;
        end
        sq = 1'b0;
    endtask

    task automatic stub_update();
        for (int i = 0; i < NDut; i++) begin
            if (rtm[i] === 1'b1) begin
                if (scnt[i] < 1000) scnt[i]++;
            end else begin
                scnt[i] = 0;
            end
            misr_ready[i] = rdy_mode && (scnt[i] > d_rdy);
            signature[i]  = misr_ready[i] ? sig_run : ~sig_run;
        end
    endtask

    task automatic check_all(input string what);
        for (int i = 0; i < NDut; i++) begin
            check($sformatf("%s dut%0d cyc%0d", what, i, cyc), 64'(got_vec(i)), 64'(exp_vec(i)));
        end
    endtask

    task automatic step();
        logic s_edge;
        s_edge = start;
        @(posedge clk);
        cyc++;
        if (rst_n) begin
            if (s_edge && !sq) begin
                for (int i = 0; i < NDut; i++) begin
                    if (!has_run[i] || (cyc - 1 - t0[i] >= dk[i])) begin
                        prev_vec[i] = exp_vec(i);
                        has_run[i]  = 1'b1;
                        t0[i]       = cyc;
                        cap[i]      = sig_run;
                        if (rdy_mode && (d_rdy <= Tmo - 1)) begin
                            exit_k[i] = 3 + lat_of(i) + d_rdy + 1;
                            dk[i]     = exit_k[i] + 1;
                            tmo[i]    = 1'b0;
                        end else begin
                            dk[i]     = 3 + lat_of(i) + Tmo;
                            exit_k[i] = dk[i];
                            tmo[i]    = 1'b1;
                        end
                    end
                end
            end
            sq = s_edge;
        end else begin
            sq = 1'b0;
        end
        #1;
        check_all("run");
        stub_update();
    endtask

    task automatic finish_run();
        int guard;
        guard = 0;
        while (!all_done() && guard < 300) begin
            step();
            guard++;
        end
        if (guard >= 300) check("run_bound", 64'(guard), 64'(0));
        repeat (3) step();
    endtask

    task automatic do_run(input logic mode, input int d, input logic [15:0] sg,
                          input int width, input int glitch_at);
        rdy_mode = mode;
        d_rdy    = d;
        sig_run  = sg;
        start    = 1'b1;
        repeat (width) step();
        start = 1'b0;
        if (glitch_at > 0) begin
            repeat (glitch_at) step();
            start = 1'b1;
            step();
            start = 1'b0;
        end
        finish_run();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] rs;
        int guard;
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        rst_n    = 1'b1;
        start    = 1'b0;
        rdy_mode = 1'b1;
        d_rdy    = 32;
        sig_run  = Golden;
        for (int i = 0; i < NDut; i++) begin
            scnt[i]       = 0;
            misr_ready[i] = 1'b0;
            signature[i]  = 16'h0000;
        end
        model_reset();

        #2 rst_n = 1'b0;
        #1;
        check_all("reset");
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();

        // Nominal pass, signature mismatch, timeout, ready/timeout tie, late ready.
        do_run(1'b1, 32, Golden, 1, -1);
        do_run(1'b1, 32, 16'hFFFF, 1, -1);
        do_run(1'b0, 0, 16'h1357, 2, -1);
        do_run(1'b1, 47, Golden, 1, -1);
        do_run(1'b1, 48, Golden, 1, -1);

        // Level start: one run only, DONE persists, then drop/raise relaunches.
        rdy_mode = 1'b1;
        d_rdy    = 32;
        sig_run  = Golden;
        start    = 1'b1;
        step();
        finish_run();
        repeat (20) step();
        start = 1'b0;
        step();
        do_run(1'b1, 33, 16'h0F0F, 1, -1);

        // Abort mid-RUN when the PIPE_LAT=1 build has issued 10 patterns.
        rdy_mode = 1'b1;
        d_rdy    = 32;
        sig_run  = Golden;
        start    = 1'b1;
        step();
        start = 1'b0;
        guard = 0;
        while (exp_vec(0)[25:20] != 6'd10 && guard < 60) begin
            step();
            guard++;
        end
        if (guard >= 60) check("abort_bound", 64'(guard), 64'(0));
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("abort");
        stub_update();
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();
        do_run(1'b1, 32, Golden, 1, -1);

        // Randomized runs, some with a start pulse while busy.
        for (int n = 0; n < 8; n++) begin
            rs = 16'($urandom);
            if ($urandom_range(0, 1) == 1) rs = Golden;
            else if (rs == Golden) rs = ~rs;
            do_run(($urandom_range(0, 7) != 0), int'($urandom_range(31, 46)), rs,
                   int'($urandom_range(1, 3)),
                   ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 25)) : -1);
            repeat ($urandom_range(0, 5)) step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bist_controller.md
# bist_controller

Sequencer for the built-in self-test of the radix-4 multiplier. It releases the pattern generator and the 16-bit MISR in a fixed order, and counts the applied patterns. It then waits for the MISR's `ready`, captures the final signature and compares it against a golden value to report pass/fail. It sits above the LFSR → radix-4 → MISR chain and owns those blocks' active-low synchronous resets.

## Interface
Parameters:
- `N_PATTERNS`, 31: patterns applied per run; the MISR compresses 31 results.
- `PIPE_LAT`, 1: cycles from LFSR output to a valid radix-4 result; range 0–7.
- `GOLDEN_SIG`, 16'h0000: expected final signature; set per netlist.
- `TIMEOUT`, 48: maximum RUN cycles allowed before `misr_ready` must be seen.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_to_bist_ctrl`  in  1  asynchronous, active-low reset.
- `start`  in  1  level; a rising edge, sampled in IDLE or DONE, launches a run.
- `misr_ready`  in  1  `ready` from the MISR.
- `signature`  in  16  signature from the MISR.
- `reset_to_lfsr`  out  1  active-low reset to the pattern generator.
- `reset_to_misr`  out  1  active-low reset to the MISR.
- `lfsr_enable`  out  1  advances the pattern generator.
- `pattern_count`  out  6  patterns issued this run.
- `sig_captured`  out  16  signature latched in COMPARE.
- `busy`  out  1  high in CLEAR, PRIME, RUN and COMPARE.
- `done`  out  1  high in DONE.
- `pass`  out  1  valid while `done`=1.
- `timeout_err`  out  1  valid while `done`=1.

## Operation
- Asynchronous reset, applied immediately:
  - state=IDLE.
  - `reset_to_lfsr`=0, `reset_to_misr`=0.
  - `lfsr_enable`=0, `pattern_count`=0, `sig_captured`=0.
  - `busy`=0, `done`=0, `pass`=0, `timeout_err`=0.
  - Internal `start_q`=0 and all internal counters=0.
- Start edge: `start`=1 while `start_q`=0. `start_q` registers `start` every cycle. A level held high does not relaunch a run.
- IDLE: both submodule resets low. A start edge moves to CLEAR.
- CLEAR (exactly 2 cycles):
  - Both resets held low so the synchronous-reset MISR seeds to 16'h8000.
  - Clears `pattern_count`, `done`, `pass`, `timeout_err`.
  - Moves to PRIME.
- PRIME (PIPE_LAT cycles; skipped when PIPE_LAT=0):
  - `reset_to_lfsr`=1, `lfsr_enable`=1, `reset_to_misr` still 0.
  - `pattern_count` increments each cycle.
  - Moves to RUN.
- RUN:
  - `reset_to_misr`=1.
  - `lfsr_enable`=1 while `pattern_count` < N_PATTERNS, then 0. `pattern_count` saturates at N_PATTERNS.
  - Watchdog counts RUN cycles from 0.
  - `misr_ready`=1 → COMPARE.
  - Watchdog reaches TIMEOUT-1 without `misr_ready` → DONE with `timeout_err`=1, `pass`=0.
  - If both events occur in the same cycle, `misr_ready` wins.
- COMPARE (1 cycle): `sig_captured` ← `signature`; `pass` ← (`signature` == GOLDEN_SIG); moves to DONE.
- DONE:
  - `done`=1, `busy`=0, `lfsr_enable`=0.
  - `reset_to_misr` stays 1 so the MISR holds its signature; `reset_to_lfsr` stays 1.
  - Results hold until a start edge, which moves to CLEAR.
- `start` edges in CLEAR, PRIME, RUN or COMPARE are ignored.
- Reset asserted mid-run aborts immediately to IDLE values; no partial result is reported.
- `pattern_count` is 6 bits. N_PATTERNS must be ≤ 63; the count never wraps.

## Timing
- Start edge sampled at edge t:
  - CLEAR occupies t+1..t+2.
  - PRIME occupies t+3..t+2+PIPE_LAT.
  - RUN is entered at t+3+PIPE_LAT; `reset_to_misr` rises on that edge.
- With the standard MISR, `misr_ready` rises 32 cycles after RUN entry. The run then reaches:
  - COMPARE at RUN entry +33.
  - DONE at RUN entry +34.
  - Total start-to-`done`: 37+PIPE_LAT cycles.
- All outputs are registered and change only on `clk` edges, except under asynchronous reset.
- `pass`, `timeout_err` and `sig_captured` become valid in the same cycle `done` rises.

## Test plan
- **Nominal pass:** GOLDEN_SIG set to the bench's model signature, PIPE_LAT=1. Pulse `start`.
  - `busy` rises 1 cycle later.
  - `reset_to_misr` rises 4 cycles after the sampled edge.
  - `done`=1 and `pass`=1 38 cycles after the edge.
  - `sig_captured` equals the model signature; `pattern_count`=31.
- **Fail:** GOLDEN_SIG=16'hFFFF against a fault-free DUT → `done`=1, `pass`=0, `timeout_err`=0.
- **Timeout:** tie `misr_ready`=0. → `done` after exactly 48 RUN cycles with `timeout_err`=1, `pass`=0.
- **Level start:** hold `start`=1 through the whole run. → Exactly one run; DONE persists. Drop then raise `start` → new run; `done` clears in CLEAR.
- **Abort:** assert `reset_to_bist_ctrl`=0 mid-RUN at `pattern_count`=10.
  - All outputs go to their reset values immediately.
  - After release, the next run completes normally.
- **PIPE_LAT=0 and PIPE_LAT=3 builds:** PRIME lasts 0 or 3 cycles. `lfsr_enable` drops exactly when `pattern_count` reaches 31.
